sys_cmd_ctrl: RTL and testbench

// - Command sequencer behind the UART receiver. Consumes received bytes (P_DATA/DATA_VALID), decodes framed commands,

---
 rtl/sys_cmd_ctrl_pkg.sv | 25 ++
 rtl/sys_tx_sequencer.sv | 73 +++++++
 rtl/sys_cmd_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_sys_cmd_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_cmd_ctrl_pkg.sv
// Shared constants for the UART command sequencer: opcodes, FSM state encoding
// and the register-file slots that hold the ALU operands.
package sys_cmd_ctrl_pkg;

    localparam logic [7:0] OP_WR      = 8'hAA;
    localparam logic [7:0] OP_RD      = 8'hBB;
    localparam logic [7:0] OP_ALU_OP  = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_WR_ADDR  = 4'd1;
    localparam logic [3:0] ST_WR_DATA  = 4'd2;
    localparam logic [3:0] ST_RD_ADDR  = 4'd3;
    localparam logic [3:0] ST_RD_WAIT  = 4'd4;
    localparam logic [3:0] ST_OPA      = 4'd5;
    localparam logic [3:0] ST_OPB      = 4'd6;
    localparam logic [3:0] ST_ALU_FUN  = 4'd7;
    localparam logic [3:0] ST_ALU_WAIT = 4'd8;
    localparam logic [3:0] ST_TX_REQ   = 4'd9;
    localparam logic [3:0] ST_TX_HOLD  = 4'd10;

    localparam int RF_ADDR_OPA = 0;
    localparam int RF_ADDR_OPB = 1;

endpackage

// File: rtl/sys_tx_sequencer.sv
// Streams a one- or two-byte result to the UART transmitter, low byte first,
// pacing each byte on the transmitter's busy flag.
module sys_tx_sequencer
    import sys_cmd_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    two_bytes,
    input  logic [2*DATA_WIDTH-1:0] data,
    input  logic                    tx_busy,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_vld,
    output logic                    done,
    output logic [3:0]              state
);

    logic [2*DATA_WIDTH-1:0] shreg;
    logic                    last;
    logic                    seen_busy;

    // Handshake: a byte is offered (tx_vld for one cycle) only while tx_busy is
    // low; the byte is considered consumed once tx_busy has risen and fallen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            last      <= 1'b0;
            seen_busy <= 1'b0;
            tx_data   <= '0;
            tx_vld    <= 1'b0;
            done      <= 1'b0;
        end else begin
            tx_vld <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg <= data;
                        last  <= !two_bytes;
                        state <= ST_TX_REQ;
                    end
                end
                ST_TX_REQ: begin
                    if (!tx_busy) begin
                        tx_vld    <= 1'b1;
                        tx_data   <= shreg[DATA_WIDTH-1:0];
                        seen_busy <= 1'b0;
                        state     <= ST_TX_HOLD;
                    end
                end
                ST_TX_HOLD: begin
                    if (tx_busy) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        if (last) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            shreg <= {{DATA_WIDTH{1'b0}}, shreg[2*DATA_WIDTH-1:DATA_WIDTH]};
                            last  <= 1'b1;
                            state <= ST_TX_REQ;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Command sequencer behind the UART receiver: decodes framed commands into
// register-file and ALU operations and returns results through the transmitter.
module sys_cmd_ctrl
    import sys_cmd_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int FUN_WIDTH   = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RF_RdData,
    input  logic                    RF_RdData_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    TX_BUSY,
    output logic                    RF_WrEn,
    output logic                    RF_RdEn,
    output logic [ADDR_WIDTH-1:0]   RF_Address,
    output logic [DATA_WIDTH-1:0]   RF_WrData,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    output logic                    FRM_ERR
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYC - 1);

    logic [3:0]              state;
    logic [CNT_W-1:0]        idle_cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [2*DATA_WIDTH-1:0] result;
    logic                    tx_start;
    logic                    tx_two;
    logic                    tx_done;
    logic                    timed;
    logic [ADDR_WIDTH-1:0]   rx_addr;

    assign rx_addr = RX_P_DATA[ADDR_WIDTH-1:0];
    assign timed   = state inside {ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_OPA, ST_OPB, ST_ALU_FUN};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= ST_IDLE;
            idle_cnt    <= '0;
            addr_q      <= '0;
            result      <= '0;
            tx_start    <= 1'b0;
            tx_two      <= 1'b0;
            RF_WrEn     <= 1'b0;
            RF_RdEn     <= 1'b0;
            RF_Address  <= '0;
            RF_WrData   <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            FRM_ERR     <= 1'b0;
        end else begin
            RF_WrEn  <= 1'b0;
            RF_RdEn  <= 1'b0;
            ALU_EN   <= 1'b0;
            FRM_ERR  <= 1'b0;
            tx_start <= 1'b0;

            // An arriving byte always beats the terminal count.
            if (timed && !RX_D_VLD) begin
                if (idle_cnt == CNT_TERM) begin
                    FRM_ERR     <= 1'b1;
                    CLK_GATE_EN <= 1'b0;
                    state       <= ST_IDLE;
                    idle_cnt    <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (RX_D_VLD) begin
                        case (RX_P_DATA)
                            DATA_WIDTH'(OP_WR):      state <= ST_WR_ADDR;
                            DATA_WIDTH'(OP_RD):      state <= ST_RD_ADDR;
                            DATA_WIDTH'(OP_ALU_OP):  state <= ST_OPA;
                            DATA_WIDTH'(OP_ALU_NOP): begin
                                CLK_GATE_EN <= 1'b1;
                                state       <= ST_ALU_FUN;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                ST_WR_ADDR: begin
                    if (RX_D_VLD) begin
                        addr_q <= rx_addr;
                        state  <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (RX_D_VLD) begin
                        RF_WrEn    <= 1'b1;
                        RF_Address <= addr_q;
                        RF_WrData  <= RX_P_DATA;
                        state      <= ST_IDLE;
                    end
                end
                ST_RD_ADDR: begin
                    if (RX_D_VLD) begin
                        RF_RdEn    <= 1'b1;
                        RF_Address <= rx_addr;
                        state      <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (RF_RdData_VLD) begin
                        result   <= {{DATA_WIDTH{1'b0}}, RF_RdData};
                        tx_two   <= 1'b0;
                        tx_start <= 1'b1;
                        state    <= ST_TX_REQ;
                    end
                end
                ST_OPA: begin
                    if (RX_D_VLD) begin
                        RF_WrEn    <= 1'b1;
                        RF_Address <= ADDR_WIDTH'(RF_ADDR_OPA);
                        RF_WrData  <= RX_P_DATA;
                        state      <= ST_OPB;
                    end
                end
                ST_OPB: begin
                    if (RX_D_VLD) begin
                        RF_WrEn     <= 1'b1;
                        RF_Address  <= ADDR_WIDTH'(RF_ADDR_OPB);
                        RF_WrData   <= RX_P_DATA;
                        CLK_GATE_EN <= 1'b1;
                        state       <= ST_ALU_FUN;
                    end
                end
                ST_ALU_FUN: begin
                    if (RX_D_VLD) begin
                        ALU_EN  <= 1'b1;
                        ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
                        state   <= ST_ALU_WAIT;
                    end
                end
                ST_ALU_WAIT: begin
                    if (ALU_OUT_VLD) begin
                        result      <= ALU_OUT;
                        CLK_GATE_EN <= 1'b0;
                        tx_two      <= 1'b1;
                        tx_start    <= 1'b1;
                        state       <= ST_TX_REQ;
                    end
                end
                // The sequencer owns the request/hold handshake; this state just waits for it.
                ST_TX_REQ: begin
                    if (tx_done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sys_tx_sequencer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tx_seq (
        .clk       (CLK),
        .rst_n     (RST),
        .start     (tx_start),
        .two_bytes (tx_two),
        .data      (result),
        .tx_busy   (TX_BUSY),
        .tx_data   (TX_P_DATA),
        .tx_vld    (TX_D_VLD),
        .done      (tx_done),
        .state     ()
    );

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Bench for sys_cmd_ctrl: directed frames, behavioural RF/ALU/TX responders,
// expected-event queue checked by an output monitor.
module tb_sys_cmd_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FW = 4;
    localparam int TO = 4096;
    localparam int W  = 16;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic [DW-1:0]   RX_P_DATA = '0;
    logic            RX_D_VLD = 1'b0;
    logic [DW-1:0]   RF_RdData = '0;
    logic            RF_RdData_VLD = 1'b0;
    logic [2*DW-1:0] ALU_OUT = '0;
    logic            ALU_OUT_VLD = 1'b0;
    logic            TX_BUSY;
    logic            RF_WrEn;
    logic            RF_RdEn;
    logic [AW-1:0]   RF_Address;
    logic [DW-1:0]   RF_WrData;
    logic            ALU_EN;
    logic [FW-1:0]   ALU_FUN;
    logic            CLK_GATE_EN;
    logic [DW-1:0]   TX_P_DATA;
    logic            TX_D_VLD;
    logic            FRM_ERR;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int tx_pulses = 0;
    int frm_pulses = 0;

    logic [7:0] rf [16];
    logic [3:0] alu_fun_q = '0;
    int         alu_pend = 0;
    int         tx_busy_cnt = 0;
    logic       force_busy = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    sys_cmd_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW), .TIMEOUT_CYC(TO)
    ) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .TX_BUSY(TX_BUSY),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address), .RF_WrData(RF_WrData),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FRM_ERR(FRM_ERR)
    );

    // ---------------- environment responders ----------------
    function automatic logic [15:0] alu_calc(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            4'd0:    return {8'h00, a} + {8'h00, b};
            4'd1:    return {8'h00, a} - {8'h00, b};
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return {8'h00, a & b};
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge CLK) begin
        RF_RdData_VLD <= 1'b0;
        if (RF_WrEn) rf[RF_Address] <= RF_WrData;
        if (RF_RdEn) begin
            RF_RdData     <= rf[RF_Address];
            RF_RdData_VLD <= 1'b1;
        end
    end

    always @(posedge CLK) begin
        ALU_OUT_VLD <= 1'b0;
        if (ALU_EN) begin
            alu_fun_q <= ALU_FUN;
            alu_pend  <= 3;
        end else if (alu_pend > 0) begin
            alu_pend <= alu_pend - 1;
            if (alu_pend == 1) begin
                ALU_OUT     <= alu_calc(alu_fun_q, rf[0], rf[1]);
                ALU_OUT_VLD <= 1'b1;
            end
        end
    end

    always @(posedge CLK) begin
        if (TX_D_VLD) tx_busy_cnt <= 12;
        else if (tx_busy_cnt > 0) tx_busy_cnt <= tx_busy_cnt - 1;
    end

    assign TX_BUSY = (tx_busy_cnt != 0) || force_busy;

    // ---------------- expected events ----------------
    function automatic logic [W-1:0] ev_wr(input logic [3:0] a, input logic [7:0] d);
        return {1'b0, 3'd1, a, d};
    endfunction
    function automatic logic [W-1:0] ev_rd(input logic [3:0] a);
        return {1'b0, 3'd2, a, 8'h00};
    endfunction
    function automatic logic [W-1:0] ev_alu(input logic [3:0] f);
        return {1'b0, 3'd3, f, 8'h00};
    endfunction
    function automatic logic [W-1:0] ev_tx(input logic [7:0] d);
        return {1'b0, 3'd4, 4'h0, d};
    endfunction
    function automatic logic [W-1:0] ev_frm();
        return {1'b0, 3'd5, 4'h0, 8'h00};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    task automatic check_event(input string name, input logic [W-1:0] got);
        logic [W-1:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected event got=%h exp=none", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s got=%h exp=%h", name, got, exp);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (RF_WrEn) check_event("rf_write", {1'b0, 3'd1, RF_Address, RF_WrData});
        if (RF_RdEn) check_event("rf_read", {1'b0, 3'd2, RF_Address, 8'h00});
        if (ALU_EN) begin
            check_event("alu_en", {1'b0, 3'd3, ALU_FUN, 8'h00});
            checks++;
            if (CLK_GATE_EN !== 1'b1) begin
                errors++;
                $display("FAIL gate_at_alu_en got=%b exp=1", CLK_GATE_EN);
            end
        end
        if (TX_D_VLD) begin
            tx_pulses++;
            check_event("tx_byte", {1'b0, 3'd4, 4'h0, TX_P_DATA});
        end
        if (FRM_ERR) begin
            frm_pulses++;
            check_event("frm_err", {1'b0, 3'd5, 4'h0, 8'h00});
        end
    end

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic check_zero(input string name);
        logic [29:0] v;
        v = {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
             CLK_GATE_EN, TX_P_DATA, TX_D_VLD, FRM_ERR};
        checks++;
        if (v !== 30'd0) begin
            errors++;
            $display("FAIL %s outputs got=%h exp=0", name, v);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain pending=%0d exp=0", name, exp_q.size());
            exp_q.delete();
        end
        idle(30);
    endtask

    // ---------------- stimulus ----------------
    int base;

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 8'h00;

        idle(4);
        check_zero("reset");
        RST = 1'b1;
        idle(3);

        // Unknown opcode dropped, then a plain write
        send_byte(8'h55);
        idle(5);
        exp_q.push_back(ev_wr(4'h5, 8'h3C));
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        wait_drain("wr", 200);

        // Write then read back through TX
        exp_q.push_back(ev_wr(4'h2, 8'h7E));
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h7E);
        wait_drain("wr2", 200);
        exp_q.push_back(ev_rd(4'h2));
        exp_q.push_back(ev_tx(8'h7E));
        send_byte(8'hBB); send_byte(8'h02);
        wait_drain("rd", 500);

        // ALU add: 0x0A + 0x03 = 0x000D
        exp_q.push_back(ev_wr(4'h0, 8'h0A));
        exp_q.push_back(ev_wr(4'h1, 8'h03));
        exp_q.push_back(ev_alu(4'h0));
        exp_q.push_back(ev_tx(8'h0D));
        exp_q.push_back(ev_tx(8'h00));
        send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h03); send_byte(8'h00);
        wait_drain("alu_add", 500);
        check_val("gate_after_add", int'(CLK_GATE_EN), 0);

        // TX back-pressure: 0x05 * 0x06 = 0x001E, bytes sent while stalled are dropped
        exp_q.push_back(ev_wr(4'h0, 8'h05));
        exp_q.push_back(ev_wr(4'h1, 8'h06));
        exp_q.push_back(ev_alu(4'h2));
        exp_q.push_back(ev_tx(8'h1E));
        exp_q.push_back(ev_tx(8'h00));
        send_byte(8'hCC); send_byte(8'h05); send_byte(8'h06);
        force_busy = 1'b1;
        send_byte(8'h02);
        base = tx_pulses;
        idle(20);
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        idle(174);
        check_val("tx_stalled", tx_pulses, base);
        force_busy = 1'b0;
        wait_drain("backpressure", 500);
        check_val("tx_pulse_count", tx_pulses, base + 2);

        // Upper address / function bits ignored: add 0x05 + 0x06 = 0x000B
        exp_q.push_back(ev_wr(4'h7, 8'h99));
        send_byte(8'hAA); send_byte(8'hF7); send_byte(8'h99);
        wait_drain("wr_upper", 200);
        exp_q.push_back(ev_alu(4'h0));
        exp_q.push_back(ev_tx(8'h0B));
        exp_q.push_back(ev_tx(8'h00));
        send_byte(8'hDD); send_byte(8'hF0);
        wait_drain("nop_upper", 500);

        // Byte one cycle past terminal count: timeout fires, late byte dropped in IDLE
        exp_q.push_back(ev_frm());
        send_byte(8'hAA); send_byte(8'h05);
        idle(TO - 1);
        send_byte(8'h3C);
        wait_drain("timeout", 200);
        exp_q.push_back(ev_wr(4'h1, 8'h11));
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h11);
        wait_drain("after_timeout", 200);

        // Byte exactly on terminal count wins
        exp_q.push_back(ev_wr(4'h6, 8'h3C));
        send_byte(8'hAA); send_byte(8'h06);
        idle(TO - 2);
        send_byte(8'h3C);
        wait_drain("byte_wins", 200);

        // Timeout while waiting for the function byte drops the clock gate
        exp_q.push_back(ev_frm());
        send_byte(8'hDD);
        idle(5);
        check_val("gate_in_alu_fun", int'(CLK_GATE_EN), 1);
        wait_drain("fun_timeout", TO + 200);
        check_val("gate_after_timeout", int'(CLK_GATE_EN), 0);

        // Reset inside an ALU frame, then clean frames
        exp_q.push_back(ev_wr(4'h0, 8'h0A));
        exp_q.push_back(ev_wr(4'h1, 8'h03));
        send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h03);
        idle(5);
        check_val("gate_before_reset", int'(CLK_GATE_EN), 1);
        RST = 1'b0;
        #2;
        check_zero("mid_frame_reset");
        idle(3);
        RST = 1'b1;
        idle(3);
        check_val("queue_before_reset_done", exp_q.size(), 0);

        exp_q.push_back(ev_wr(4'h0, 8'h10));
        exp_q.push_back(ev_wr(4'h1, 8'h20));
        exp_q.push_back(ev_alu(4'h2));
        exp_q.push_back(ev_tx(8'h00));
        exp_q.push_back(ev_tx(8'h02));
        send_byte(8'hCC); send_byte(8'h10); send_byte(8'h20); send_byte(8'h02);
        wait_drain("alu_mul", 500);

        // 0x10 - 0x20 wraps to 0xFFF0
        exp_q.push_back(ev_alu(4'h1));
        exp_q.push_back(ev_tx(8'hF0));
        exp_q.push_back(ev_tx(8'hFF));
        send_byte(8'hDD); send_byte(8'h01);
        wait_drain("alu_sub", 500);

        check_val("frm_err_count", frm_pulses, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
